// File: rtl/calc3_loader_pkg.sv
// calc3_loader_pkg: state encoding, operand count and default widths shared by calc3_loader
package calc3_loader_pkg;
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam int N_OPS = 6;
    localparam int W_IN_DEF = 6;
    localparam int W_OUT_DEF = 10;
endpackage

// File: rtl/calc3_loader.sv
// calc3_loader: collects six operand beats for calculate3, then captures and holds its result
module calc3_loader
    import calc3_loader_pkg::*;
#(
    parameter int W_IN = W_IN_DEF,
    parameter int W_OUT = W_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic [W_IN-1:0]  n0,
    output logic [W_IN-1:0]  n1,
    output logic [W_IN-1:0]  n2,
    output logic [W_IN-1:0]  n3,
    output logic [W_IN-1:0]  n4,
    output logic [W_IN-1:0]  n5,
    output logic [1:0]       mode,
    input  logic [W_OUT-1:0] calc_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_OUT-1:0] res_data
);
    logic [1:0]      state;
    logic [2:0]      cnt;
    logic [W_IN-1:0] n_q [N_OPS];
    logic            last;
    assign last      = cnt == 3'(N_OPS - 1);
    assign in_ready  = state == ST_LOAD;
    assign res_valid = state == ST_HOLD;
    assign n0 = n_q[0];
    assign n1 = n_q[1];
    assign n2 = n_q[2];
    assign n3 = n_q[3];
    assign n4 = n_q[4];
    assign n5 = n_q[5];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOAD;
            cnt      <= '0;
            mode     <= '0;
            res_data <= '0;
            for (int i = 0; i < N_OPS; i++) n_q[i] <= '0;
        end else begin
            case (state)
                ST_LOAD: if (in_valid) begin
                    n_q[cnt] <= in_data;
                    if (cnt == '0) mode <= in_mode;
                    cnt <= last ? '0 : cnt + 3'd1;
                    if (last) state <= ST_EVAL;
                end
                // calculate3 is combinational on the N registers, so its output is settled here
                ST_EVAL: begin
                    res_data <= calc_result;
                    state    <= ST_HOLD;
                end
                ST_HOLD: if (res_ready) state <= ST_LOAD;
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_calc3_loader.sv
// tb_calc3_loader: directed vectors against calc3_loader with a summing calculate3 stub
module tb_calc3_loader;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [5:0] in_data = '0;
    logic [1:0] in_mode = '0;
    logic [5:0] n0, n1, n2, n3, n4, n5;
    logic [1:0] mode;
    logic [9:0] calc_result;
    logic       res_valid;
    logic       res_ready = 0;
    logic [9:0] res_data;
    int n_chk = 0;
    int n_pass = 0;

    calc3_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5), .mode(mode),
        .calc_result(calc_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    assign calc_result = 10'(n0) + 10'(n1) + 10'(n2) + 10'(n3) + 10'(n4) + 10'(n5);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [5:0] d, input logic [1:0] m);
        in_valid = 1;
        in_data  = d;
        in_mode  = m;
        tick();
    endtask

    task automatic finish_set(input logic [9:0] exp_sum);
        in_valid = 0;
        chk("eval_no_valid", 32'(res_valid), 0);
        chk("eval_not_ready", 32'(in_ready), 0);
        tick();
        chk("hold_valid", 32'(res_valid), 1);
        chk("hold_data", 32'(res_data), 32'(exp_sum));
    endtask

    task automatic release_result();
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("back_to_load", 32'(in_ready), 1);
        chk("valid_dropped", 32'(res_valid), 0);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_n0", 32'(n0), 0);
        chk("rst_mode", 32'(mode), 0);
        rst_n = 1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 1);

        // basic set
        beat(27, 2); beat(11, 0); beat(10, 0); beat(5, 0); beat(3, 0); beat(1, 0);
        finish_set(57);
        chk("basic_n0", 32'(n0), 27);
        chk("basic_n1", 32'(n1), 11);
        chk("basic_n2", 32'(n2), 10);
        chk("basic_n3", 32'(n3), 5);
        chk("basic_n4", 32'(n4), 3);
        chk("basic_n5", 32'(n5), 1);
        chk("basic_mode", 32'(mode), 2);
        release_result();
        chk("basic_data_kept", 32'(res_data), 57);

        // stall after beat 2
        beat(1, 0); beat(2, 0); beat(3, 0);
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", 32'(in_ready), 1);
            chk("stall_n3", 32'(n3), 5);
            chk("stall_n5", 32'(n5), 1);
        end
        beat(4, 0); beat(5, 0); beat(6, 0);
        finish_set(21);
        chk("stall_n3_new", 32'(n3), 4);
        chk("stall_n5_new", 32'(n5), 6);
        chk("stall_mode", 32'(mode), 0);

        // backpressure with a waiting producer
        in_valid = 1;
        in_data  = 9;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_data", 32'(res_data), 21);
            chk("bp_ready", 32'(in_ready), 0);
        end
        chk("bp_n0", 32'(n0), 1);
        in_valid = 0;
        release_result();

        // mode isolation
        beat(0, 1); beat(0, 3); beat(0, 3); beat(0, 3); beat(0, 3); beat(7, 3);
        finish_set(7);
        chk("iso_mode", 32'(mode), 1);
        release_result();

        // back-to-back with res_ready tied high
        res_ready = 1;
        for (int i = 0; i < 6; i++) beat(63, 0);
        in_data = 1;
        chk("b2b_eval", 32'(in_ready), 0);
        tick();
        chk("b2b_hold", 32'(res_valid), 1);
        chk("b2b_378", 32'(res_data), 378);
        tick();
        chk("b2b_load", 32'(in_ready), 1);
        for (int i = 0; i < 6; i++) tick();
        in_valid = 0;
        chk("b2b_n0", 32'(n0), 1);
        chk("b2b_n5", 32'(n5), 1);
        chk("b2b_eval2", 32'(in_ready), 0);
        tick();
        chk("b2b_6", 32'(res_data), 6);
        tick();
        res_ready = 0;
        chk("b2b_done", 32'(in_ready), 1);

        // asynchronous reset after beat 3
        beat(10, 2); beat(20, 0); beat(30, 0); beat(40, 0);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_n0", 32'(n0), 0);
        chk("arst_n3", 32'(n3), 0);
        chk("arst_mode", 32'(mode), 0);
        chk("arst_data", 32'(res_data), 0);
        chk("arst_ready", 32'(in_ready), 1);
        #1 rst_n = 1;
        beat(2, 3); beat(2, 0); beat(2, 0); beat(2, 0); beat(2, 0); beat(5, 0);
        finish_set(15);
        chk("fresh_n0", 32'(n0), 2);
        chk("fresh_n5", 32'(n5), 5);
        chk("fresh_mode", 32'(mode), 3);

        // reset while holding a result
        #2 rst_n = 0;
        #1;
        chk("hrst_valid", 32'(res_valid), 0);
        chk("hrst_data", 32'(res_data), 0);
        chk("hrst_ready", 32'(in_ready), 1);
        #1 rst_n = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/calc3_loader.md
CALC3_LOADER -- requirements
Module: calc3_loader

Interface
REQ-001 Parameter W_IN, default 6, SHALL set the operand width.
REQ-002 Parameter W_OUT, default 10, SHALL set the result width.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 IN_VALID  input  1  SHALL indicate that IN_DATA/IN_MODE carry an operand beat.
REQ-006 IN_READY  output  1  SHALL indicate that the block accepts a beat this cycle.
REQ-007 IN_DATA  input  W_IN  SHALL carry the operand value.
REQ-008 IN_MODE  input  2  SHALL carry the operation mode, meaningful on the first beat of a set only.
REQ-009 N0..N5  output  W_IN each  SHALL present the registered operands to the downstream calculate3 block.
REQ-010 MODE  output  2  SHALL present the registered mode to calculate3.
REQ-011 CALC_RESULT  input  W_OUT  SHALL receive OUT_N from calculate3.
REQ-012 RES_VALID  output  1  SHALL indicate that RES_DATA holds a valid captured result.
REQ-013 RES_READY  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-014 RES_DATA  output  W_OUT  SHALL hold the captured result.

Function
REQ-015 FSM states SHALL be LOAD, EVAL and HOLD.
REQ-016 A beat SHALL be accepted on a rising edge when IN_VALID=1 and IN_READY=1.
REQ-017 IN_READY SHALL be 1 in LOAD only, decoded combinationally from state.
REQ-018 A 3-bit beat counter SHALL select N0..N5 in order (beat 0 -> N0).
- Each accepted beat writes its N register and increments the counter.
REQ-019 On beat 0, IN_MODE SHALL be written to MODE; IN_MODE SHALL be ignored on beats 1-5.
REQ-020 On acceptance of beat 5:
- counter SHALL wrap to 0
- FSM SHALL go LOAD -> EVAL.
REQ-021 EVAL SHALL last exactly one cycle.
- At its closing edge, CALC_RESULT SHALL be captured into RES_DATA.
- FSM SHALL go to HOLD.
REQ-022 RES_VALID SHALL be 1 exactly while in HOLD, so it rises 2 edges after beat 5 is accepted.
REQ-023 In HOLD, RES_READY=1 SHALL return the FSM to LOAD on the next edge.
- IN_READY SHALL not rise before that edge, so the next set cannot overlap.
REQ-024 RES_DATA, N0..N5 and MODE SHALL retain their values until overwritten.
REQ-025 IN_VALID low mid-set SHALL stall the set with the counter held.
- There is no timeout.
REQ-026 RES_READY outside HOLD SHALL have no effect.

Reset
REQ-027 RST_N low SHALL immediately set the following, regardless of CLK:
- FSM = LOAD, counter = 0
- N0..N5 = 0, MODE = 0, RES_DATA = 0, RES_VALID = 0.
REQ-028 Reset mid-set or mid-HOLD SHALL discard partial operands and any pending result.
REQ-029 After RST_N rises, IN_READY SHALL be 1 on the first cycle.

Structure
REQ-030 A shared package SHALL hold:
- the state encoding (LOAD=0, EVAL=1, HOLD=2)
- the operand count constant (6)
- the default widths.
REQ-031 The block SHALL be flat with no sub-module; calculate3 is instantiated beside it at the next level up.

Verification
REQ-032 The bench SHALL connect CALC_RESULT to a stub returning N0+N1+N2+N3+N4+N5.
REQ-033 Basic set: beats 27,11,10,5,3,1 with IN_MODE=2 on beat 0, then RES_READY=1 ->
- N0..N5 = 27,11,10,5,3,1, MODE=2
- RES_VALID rises 2 edges after the 6th beat
- RES_DATA=57
- IN_READY returns to 1 one cycle later.
REQ-034 Stall: IN_VALID low for 3 cycles after beat 2 -> counter holds at 3, N3..N5 unchanged, and the set completes normally.
REQ-035 Backpressure: RES_READY held low for 10 cycles ->
- RES_VALID stays 1 and RES_DATA stable
- IN_READY stays 0 while IN_VALID is held 1.
REQ-036 Mode isolation: IN_MODE=1 on beat 0 and IN_MODE=3 on beats 1-5 -> MODE=1.
REQ-037 Back-to-back sets:
- set 1: all beats 63 with RES_READY tied 1 -> RES_DATA=378
- set 2: all beats 1 -> RES_DATA=6, with no lost beats.
REQ-038 Reset mid-set: RST_N pulsed low after beat 3 -> all outputs 0 asynchronously; a fresh 6-beat set then loads from N0.
